// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single-transaction SRAM controller.
// IDLE picks a winner and latches its request, ISSUE drives the controller, RESP hands back ready.
module sram_arbiter #(
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_rd_req,
  input  logic        p0_wr_req,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic [31:0] p0_rdata,
  output logic        p0_ready,
  input  logic        p1_rd_req,
  input  logic        p1_wr_req,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic [31:0] p1_rdata,
  output logic        p1_ready,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  input  logic        mem_ready,
  output logic [1:0]  grant,
  output logic        err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]  r_state;
  logic        r_owner;
  logic        r_wr;
  logic        r_last;
  logic        r_err;
  logic [7:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;

  logic w_req0;
  logic w_req1;
  logic w_win;
  logic w_busy;

  assign w_req0 = p0_rd_req | p0_wr_req;
  assign w_req1 = p1_rd_req | p1_wr_req;
  assign w_busy = (r_state == S_ISSUE) || (r_state == S_RESP);

  // On a tie the port that did not win last time gets it (r_last=1 -> port 0).
  always_comb begin
    w_win = 1'b0;
    if (w_req0 && w_req1)
      w_win = (PRIO_MODE != 0) ? 1'b0 : ~r_last;
    else
      w_win = ~w_req0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_owner  <= 1'b0;
      r_wr     <= 1'b0;
      r_last   <= 1'b1;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req0 || w_req1) begin
            r_state <= S_ISSUE;
            r_owner <= w_win;
            r_last  <= w_win;
            r_cnt   <= 8'd1;
            if (w_win) begin
              r_addr  <= p1_addr;
              r_wdata <= p1_wdata;
              r_wr    <= p1_wr_req;
            end else begin
              r_addr  <= p0_addr;
              r_wdata <= p0_wdata;
              r_wr    <= p0_wr_req;
            end
          end
        end
        S_ISSUE: begin
          if (mem_ready) begin
            r_state <= S_RESP;
            if (!r_wr) begin
              if (r_owner) r_rdata1 <= mem_read_data;
              else         r_rdata0 <= mem_read_data;
            end
          end else if (r_cnt == 8'(TIMEOUT)) begin
            r_state <= S_RESP;
            r_err   <= 1'b1;
            if (!r_wr) begin
              if (r_owner) r_rdata1 <= '0;
              else         r_rdata0 <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_read_en    = (r_state == S_ISSUE) & ~r_wr;
  assign mem_write_en   = (r_state == S_ISSUE) &  r_wr;
  assign mem_address    = r_addr;
  assign mem_write_data = r_wdata;
  assign grant          = w_busy ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign err            = r_err;
  assign p0_rdata       = r_rdata0;
  assign p1_rdata       = r_rdata1;
  assign p0_ready       = ~w_req0 | ((r_state == S_RESP) & ~r_owner);
  assign p1_ready       = ~w_req1 | ((r_state == S_RESP) &  r_owner);

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a round-robin instance (TIMEOUT=16) and a fixed-priority one (TIMEOUT=4).
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        rd0 [2], wr0 [2], rd1 [2], wr1 [2], mr [2];
  logic [31:0] a0 [2], d0 [2], a1 [2], d1 [2], mrd [2];
  logic [31:0] q0 [2], q1 [2], maddr [2], mwd [2];
  logic        rdy0 [2], rdy1 [2], ren [2], wen [2], er [2];
  logic [1:0]  g [2];

  int n_chk = 0;
  int n_err = 0;

  sram_arbiter #(.PRIO_MODE(0), .TIMEOUT(16)) u_rr (
    .clk(clk), .reset(rst),
    .p0_rd_req(rd0[0]), .p0_wr_req(wr0[0]), .p0_addr(a0[0]), .p0_wdata(d0[0]),
    .p0_rdata(q0[0]), .p0_ready(rdy0[0]),
    .p1_rd_req(rd1[0]), .p1_wr_req(wr1[0]), .p1_addr(a1[0]), .p1_wdata(d1[0]),
    .p1_rdata(q1[0]), .p1_ready(rdy1[0]),
    .mem_read_en(ren[0]), .mem_write_en(wen[0]), .mem_address(maddr[0]),
    .mem_write_data(mwd[0]), .mem_read_data(mrd[0]), .mem_ready(mr[0]),
    .grant(g[0]), .err(er[0])
  );

  sram_arbiter #(.PRIO_MODE(1), .TIMEOUT(4)) u_fp (
    .clk(clk), .reset(rst),
    .p0_rd_req(rd0[1]), .p0_wr_req(wr0[1]), .p0_addr(a0[1]), .p0_wdata(d0[1]),
    .p0_rdata(q0[1]), .p0_ready(rdy0[1]),
    .p1_rd_req(rd1[1]), .p1_wr_req(wr1[1]), .p1_addr(a1[1]), .p1_wdata(d1[1]),
    .p1_rdata(q1[1]), .p1_ready(rdy1[1]),
    .mem_read_en(ren[1]), .mem_write_en(wen[1]), .mem_address(maddr[1]),
    .mem_write_data(mwd[1]), .mem_read_data(mrd[1]), .mem_ready(mr[1]),
    .grant(g[1]), .err(er[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Transaction-level reference: one outstanding transfer, phase 0/1/2 = arbitrate/wait/handback.
  int          PM [2] = '{0, 1};
  int          TO [2] = '{16, 4};
  int          m_phase [2], m_owner [2], m_wait [2], m_last [2];
  logic        m_wr [2], m_err [2];
  logic [31:0] m_addr [2], m_wd [2], m_q0 [2], m_q1 [2];
  logic        m_prdy0 [2], m_prdy1 [2];

  task automatic model_step(input int k);
    logic        r0, r1;
    logic [31:0] v;
    int          w;
    r0 = rd0[k] | wr0[k];
    r1 = rd1[k] | wr1[k];
    if (rst) begin
      m_phase[k] = 0; m_owner[k] = 0; m_wait[k] = 0; m_last[k] = 1;
      m_wr[k] = 1'b0; m_err[k] = 1'b0; m_addr[k] = '0; m_wd[k] = '0;
      m_q0[k] = '0; m_q1[k] = '0;
    end else if (m_phase[k] == 0) begin
      if (r0 || r1) begin
        if (r0 && r1) w = (PM[k] == 1) ? 0 : 1 - m_last[k];
        else          w = r0 ? 0 : 1;
        m_owner[k] = w;
        m_last[k]  = w;
        m_wr[k]    = (w == 1) ? wr1[k] : wr0[k];
        m_addr[k]  = (w == 1) ? a1[k] : a0[k];
        m_wd[k]    = (w == 1) ? d1[k] : d0[k];
        m_wait[k]  = 1;
        m_phase[k] = 1;
      end
    end else if (m_phase[k] == 1) begin
      if (mr[k] || m_wait[k] >= TO[k]) begin
        if (!mr[k]) m_err[k] = 1'b1;
        v = mr[k] ? mrd[k] : 32'h0;
        if (!m_wr[k]) begin
          if (m_owner[k] == 1) m_q1[k] = v;
          else                 m_q0[k] = v;
        end
        m_phase[k] = 2;
      end else begin
        m_wait[k]++;
      end
    end else begin
      m_phase[k] = 0;
    end
  endtask

  task automatic model_check(input int k);
    logic [1:0] eg;
    string      t;
    t  = $sformatf("rnd%0d_", k);
    eg = (m_phase[k] == 0) ? 2'b00 : ((m_owner[k] == 1) ? 2'b10 : 2'b01);
    m_prdy0[k] = !(rd0[k] | wr0[k]) || (m_phase[k] == 2 && m_owner[k] == 0);
    m_prdy1[k] = !(rd1[k] | wr1[k]) || (m_phase[k] == 2 && m_owner[k] == 1);
    chk({t, "grant"}, 32'(g[k]), 32'(eg));
    chk({t, "rd_en"}, 32'(ren[k]), 32'(m_phase[k] == 1 && !m_wr[k]));
    chk({t, "wr_en"}, 32'(wen[k]), 32'(m_phase[k] == 1 && m_wr[k]));
    chk({t, "addr"}, maddr[k], m_addr[k]);
    chk({t, "wdata"}, mwd[k], m_wd[k]);
    chk({t, "p0_ready"}, 32'(rdy0[k]), 32'(m_prdy0[k]));
    chk({t, "p1_ready"}, 32'(rdy1[k]), 32'(m_prdy1[k]));
    chk({t, "p0_rdata"}, q0[k], m_q0[k]);
    chk({t, "p1_rdata"}, q1[k], m_q1[k]);
    chk({t, "err"}, 32'(er[k]), 32'(m_err[k]));
  endtask

  typedef struct {
    logic [31:0] rd0, wr0, rd1, wr1, a0, d0, a1, d1, mr, mrd;
    logic [31:0] g, ren, wen, rdy0, rdy1, maddr, mwd, q0, q1;
  } vec_t;
  vec_t tbl [20];

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before the bench finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c0, c1, bad;
    logic done;
    //            rd0 wr0 rd1 wr1 a0      d0    a1     d1    mr mrd           g  ren wen r0 r1 maddr  mwd    q0           q1
    tbl[0]  = '{0,0,0,0, 'h0,  'h0, 'h0, 'h0, 0,'h0,        0,0,0,1,1, 'h0,  'h0,  'h0,        'h0};
    tbl[1]  = '{1,0,0,0, 'h400,'h0, 'h0, 'h0, 0,'h0,        0,0,0,0,1, 'h0,  'h0,  'h0,        'h0};
    tbl[2]  = '{1,0,0,0, 'h999,'h77,'h0, 'h0, 0,'h0,        1,1,0,0,1, 'h400,'h0,  'h0,        'h0};
    tbl[3]  = '{1,0,0,0, 'h999,'h77,'h0, 'h0, 0,'h0,        1,1,0,0,1, 'h400,'h0,  'h0,        'h0};
    tbl[4]  = '{1,0,0,0, 'h999,'h77,'h0, 'h0, 1,'hCAFEF00D, 1,1,0,0,1, 'h400,'h0,  'h0,        'h0};
    tbl[5]  = '{1,0,0,0, 'h999,'h77,'h0, 'h0, 0,'h0,        1,0,0,1,1, 'h400,'h0,  'hCAFEF00D, 'h0};
    tbl[6]  = '{0,0,0,0, 'h0,  'h0, 'h0, 'h0, 0,'h0,        0,0,0,1,1, 'h400,'h0,  'hCAFEF00D, 'h0};
    tbl[7]  = '{0,0,1,1, 'h0,  'h0, 'h10,'h5A,0,'h0,        0,0,0,1,0, 'h400,'h0,  'hCAFEF00D, 'h0};
    tbl[8]  = '{0,0,1,1, 'h0,  'h0, 'h10,'h5A,1,'hDEADBEEF, 2,0,1,1,0, 'h10, 'h5A, 'hCAFEF00D, 'h0};
    tbl[9]  = '{0,0,1,1, 'h0,  'h0, 'h10,'h5A,0,'h0,        2,0,0,1,1, 'h10, 'h5A, 'hCAFEF00D, 'h0};
    tbl[10] = '{0,1,1,0, 'h20, 'h11,'h30,'h0, 0,'h0,        0,0,0,0,0, 'h10, 'h5A, 'hCAFEF00D, 'h0};
    tbl[11] = '{0,1,1,0, 'h20, 'h11,'h30,'h0, 1,'h0,        1,0,1,0,0, 'h20, 'h11, 'hCAFEF00D, 'h0};
    tbl[12] = '{0,1,1,0, 'h20, 'h11,'h30,'h0, 0,'h0,        1,0,0,1,0, 'h20, 'h11, 'hCAFEF00D, 'h0};
    tbl[13] = '{0,1,1,0, 'h40, 'h22,'h30,'h0, 0,'h0,        0,0,0,0,0, 'h20, 'h11, 'hCAFEF00D, 'h0};
    tbl[14] = '{0,1,1,0, 'h40, 'h22,'h30,'h0, 1,'h12345678, 2,1,0,0,0, 'h30, 'h0,  'hCAFEF00D, 'h0};
    tbl[15] = '{0,1,1,0, 'h40, 'h22,'h30,'h0, 0,'h0,        2,0,0,0,1, 'h30, 'h0,  'hCAFEF00D, 'h12345678};
    tbl[16] = '{0,1,1,0, 'h40, 'h22,'h30,'h0, 0,'h0,        0,0,0,0,0, 'h30, 'h0,  'hCAFEF00D, 'h12345678};
    tbl[17] = '{0,1,1,0, 'h40, 'h22,'h30,'h0, 1,'h0,        1,0,1,0,0, 'h40, 'h22, 'hCAFEF00D, 'h12345678};
    tbl[18] = '{0,1,1,0, 'h40, 'h22,'h30,'h0, 0,'h0,        1,0,0,1,0, 'h40, 'h22, 'hCAFEF00D, 'h12345678};
    tbl[19] = '{0,0,0,0, 'h0,  'h0, 'h0, 'h0, 0,'h0,        0,0,0,1,1, 'h40, 'h22, 'hCAFEF00D, 'h12345678};

    for (int k = 0; k < 2; k++) begin
      rd0[k] = 0; wr0[k] = 0; rd1[k] = 0; wr1[k] = 0; mr[k] = 0;
      a0[k] = '0; d0[k] = '0; a1[k] = '0; d1[k] = '0; mrd[k] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset%0d_grant", k), 32'(g[k]), 0);
      chk($sformatf("reset%0d_en", k), 32'({ren[k], wen[k]}), 0);
      chk($sformatf("reset%0d_addr", k), maddr[k], 0);
      chk($sformatf("reset%0d_rdata", k), q0[k] | q1[k], 0);
      chk($sformatf("reset%0d_err", k), 32'(er[k]), 0);
    end
    rst = 1'b0;

    // Single read, write-wins-over-read, round-robin tie order, latch isolation.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rd0[0] = tbl[i].rd0[0]; wr0[0] = tbl[i].wr0[0];
      rd1[0] = tbl[i].rd1[0]; wr1[0] = tbl[i].wr1[0];
      a0[0] = tbl[i].a0; d0[0] = tbl[i].d0; a1[0] = tbl[i].a1; d1[0] = tbl[i].d1;
      mr[0] = tbl[i].mr[0]; mrd[0] = tbl[i].mrd;
      #1;
      chk($sformatf("row%0d_grant", i), 32'(g[0]), tbl[i].g);
      chk($sformatf("row%0d_rd_en", i), 32'(ren[0]), tbl[i].ren);
      chk($sformatf("row%0d_wr_en", i), 32'(wen[0]), tbl[i].wen);
      chk($sformatf("row%0d_p0_ready", i), 32'(rdy0[0]), tbl[i].rdy0);
      chk($sformatf("row%0d_p1_ready", i), 32'(rdy1[0]), tbl[i].rdy1);
      chk($sformatf("row%0d_addr", i), maddr[0], tbl[i].maddr);
      chk($sformatf("row%0d_wdata", i), mwd[0], tbl[i].mwd);
      chk($sformatf("row%0d_p0_rdata", i), q0[0], tbl[i].q0);
      chk($sformatf("row%0d_p1_rdata", i), q1[0], tbl[i].q1);
    end

    // Timeout: mem_ready never comes for a p1 read.
    @(negedge clk);
    rd1[0] = 1; a1[0] = 'h50; mr[0] = 0;
    n = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk); #1;
      if (rdy1[0]) done = 1;
      else if (ren[0]) n++;
    end
    chk("timeout_reached", 32'(done), 1);
    chk("timeout_issue_cycles", n, 16);
    chk("timeout_grant", 32'(g[0]), 2);
    chk("timeout_err", 32'(er[0]), 1);
    chk("timeout_p1_rdata", q1[0], 0);
    rd1[0] = 0;
    @(negedge clk);
    wr0[0] = 1; d0[0] = 'h33; mr[0] = 1;
    @(negedge clk);
    @(negedge clk); #1;
    chk("after_timeout_ready", 32'(rdy0[0]), 1);
    chk("err_sticky", 32'(er[0]), 1);
    wr0[0] = 0;

    // Reset on the second ISSUE cycle; address change during ISSUE.
    @(negedge clk);
    rd0[0] = 1; a0[0] = 'h500; mr[0] = 0;
    @(negedge clk);
    a0[0] = 'h600; #1;
    chk("issue_addr_latched", maddr[0], 'h500);
    @(negedge clk);
    rst = 1'b1; #1;
    chk("issue2_p0_ready", 32'(rdy0[0]), 0);
    @(negedge clk); #1;
    chk("midrst_grant", 32'(g[0]), 0);
    chk("midrst_en", 32'({ren[0], wen[0]}), 0);
    chk("midrst_addr", maddr[0], 0);
    chk("midrst_wdata", mwd[0], 0);
    chk("midrst_p0_rdata", q0[0], 0);
    chk("midrst_p1_rdata", q1[0], 0);
    chk("midrst_err", 32'(er[0]), 0);
    chk("midrst_p0_ready", 32'(rdy0[0]), 0);
    rst = 1'b0; rd0[0] = 0;

    // Fixed priority: both ports request continuously.
    @(negedge clk);
    wr0[1] = 1; rd1[1] = 1; mr[1] = 1; d0[1] = 'h44;
    c0 = 0; c1 = 0; bad = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (g[1] == 2'b10) bad++;
      if (rdy1[1]) c1++;
      if (rdy0[1] && g[1] == 2'b01) c0++;
      @(negedge clk);
    end
    chk("prio_p0_completions", c0, 10);
    chk("prio_p1_ready_seen", c1, 0);
    chk("prio_p1_grants", bad, 0);
    wr0[1] = 0; rd1[1] = 0;

    // Randomised traffic on both instances against the reference model.
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rd0[k] = 0; wr0[k] = 0; rd1[k] = 0; wr1[k] = 0;
      m_prdy0[k] = 1; m_prdy1[k] = 1;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
    for (int c = 0; c < 3000 && n_err < 200; c++) begin
      @(negedge clk);
      rst = ($urandom_range(99) == 0);
      for (int k = 0; k < 2; k++) begin
        if ((rd0[k] | wr0[k]) && (m_prdy0[k] || $urandom_range(15) == 0)) begin
          rd0[k] = 0; wr0[k] = 0;
        end
        if (!(rd0[k] | wr0[k]) && $urandom_range(2) == 0)
          {rd0[k], wr0[k]} = 2'($urandom_range(3, 1));
        if ((rd1[k] | wr1[k]) && (m_prdy1[k] || $urandom_range(15) == 0)) begin
          rd1[k] = 0; wr1[k] = 0;
        end
        if (!(rd1[k] | wr1[k]) && $urandom_range(2) == 0)
          {rd1[k], wr1[k]} = 2'($urandom_range(3, 1));
        a0[k] = $urandom; d0[k] = $urandom; a1[k] = $urandom; d1[k] = $urandom;
        mrd[k] = $urandom;
        mr[k] = (k == 0) ? ($urandom_range(1) == 0) : ($urandom_range(3) == 0);
      end
      #1;
      for (int k = 0; k < 2; k++) model_check(k);
      @(posedge clk);
      for (int k = 0; k < 2; k++) model_step(k);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority with port 0 highest.
REQ-002 Parameter: TIMEOUT, 16, maximum number of ISSUE cycles to wait for mem_ready before aborting (range 2..255).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 pN_rd_req, pN_wr_req (N=0,1)  in  1 each  read/write request; held by the requester until pN_ready is sampled high.
REQ-007 pN_addr, pN_wdata  in  32 each  byte address and write data for port N.
REQ-008 pN_rdata  out  32  read data for port N; registered.
REQ-009 pN_ready  out  1  low while port N has an outstanding, uncompleted request (pipeline freeze).
REQ-010 mem_read_en, mem_write_en  out  1 each  to SRAM controller read_en/write_en.
REQ-011 mem_address, mem_write_data  out  32 each  to SRAM controller address/writeData.
REQ-012 mem_read_data  in  32  from SRAM controller readData.
REQ-013 mem_ready  in  1  from SRAM controller SRAM_ready.
REQ-014 grant  out  2  one-hot owner of the current transaction (bit N = port N); 0 when IDLE.
REQ-015 err  out  1  sticky timeout flag.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, RESP.
REQ-017 IDLE: if any request is pending, the winner SHALL be selected, its address, data and op latched, and the FSM SHALL enter ISSUE on the next edge; otherwise remain in IDLE.
REQ-018 Round-robin: when both ports request, the port not granted most recently SHALL win; the last-grant pointer resets to port 1, so port 0 wins the first tie.
REQ-019 PRIO_MODE=1: port 0 SHALL always win ties.
REQ-020 pN_wr_req and pN_rd_req both high on one port SHALL be treated as a write; the read is not performed.
REQ-021 ISSUE: mem_write_en or mem_read_en (exactly one) SHALL be high, and mem_address/mem_write_data SHALL be driven from the latched values, unaffected by later pN_* changes.
REQ-022 Completion SHALL be detected when mem_ready=1 in an ISSUE cycle; on that edge a read SHALL capture mem_read_data into the owner's pN_rdata, and the FSM SHALL enter RESP.
REQ-023 An ISSUE cycle counter SHALL count from 1; if it reaches TIMEOUT without mem_ready, the FSM SHALL enter RESP, set err, and, for a read, load 0 into pN_rdata.
REQ-024 RESP: both mem enables SHALL be low (lets the SRAM controller return to its start state), and the owner's pN_ready SHALL be high for exactly this cycle; next state IDLE.
REQ-025 pN_ready SHALL be (no request on port N) OR (RESP and grant[N]); it is combinational from the request inputs.
REQ-026 A request dropped by a requester before completion SHALL NOT abort the transaction; it completes and the result is discarded by that requester.
REQ-027 The non-owner's pN_rdata SHALL hold its value through any transaction.
REQ-028 A new request arriving in RESP SHALL be arbitrated in the following IDLE cycle; minimum spacing between transactions is 3 cycles (IDLE, ISSUE, RESP).
REQ-029 The last-grant pointer SHALL update on entry to ISSUE.

Reset
REQ-030 While reset is high at a clock edge: state IDLE, grant 0, mem enables 0, mem_address 0, mem_write_data 0, both pN_rdata 0, err 0, ISSUE counter 0, last-grant pointer 1.
REQ-031 Reset asserted mid-transaction SHALL abandon it with no pN_ready pulse issued and no rdata update.
REQ-032 err SHALL be cleared only by reset.

Verification
REQ-033 Single read: p0_rd_req, p0_addr=0x400; memory model raises mem_ready on the 3rd ISSUE cycle with data 0xCAFEF00D -> mem_read_en high for 3 cycles, p0_rdata=0xCAFEF00D, p0_ready high in the RESP cycle only.
REQ-034 Simultaneous: p0 write 0x11 and p1 read, both held; PRIO_MODE=0 -> grant order 01, 10; the p1 read issues at the IDLE cycle after p0's RESP; p0 again -> p0 wins the next tie only after p1.
REQ-035 PRIO_MODE=1 with both ports requesting continuously -> port 0 is granted every transaction; p1_ready stays low.
REQ-036 rd+wr both high on p1 with p1_wdata=0x5A -> only mem_write_en is asserted; mem_write_data=0x5A.
REQ-037 mem_ready held low, TIMEOUT=16 -> RESP after 16 ISSUE cycles, err=1, pN_rdata=0; err stays 1 across later good transactions.
REQ-038 Reset pulsed on the 2nd ISSUE cycle -> next cycle all outputs at reset values and no pN_ready pulse; pN_addr changed during ISSUE -> mem_address unchanged.
